// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-port, packet-granular round-robin arbiter for a UART.
// Define ARB_TIMEOUT_EN to revoke grants that stall in GRANT for TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_ld,
  input  logic [1:0]  req_last,
  output logic [1:0]  gnt,
  output logic [1:0]  req_ack,
  output logic [7:0]  tx_data,
  output logic        ld_tx_data,
  output logic        tx_enable,
  input  logic        tx_empty,
  output logic        timeout_flag
);

  typedef enum logic [2:0] {
    IDLE, GRANT, LOAD, HOLD, WAIT_TX
  } state_t;

  state_t     state, state_nx;
  logic [1:0] gnt_nx;
  logic [7:0] byte_q, byte_nx;
  logic       last_q, last_nx;
  logic       ptr, ptr_nx;
  logic       sel;
  logic       g_req, g_ld, g_last;
  logic [7:0] g_data;
  logic       accept;
  logic       tmo;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign sel    = gnt[1];
  assign g_req  = req[sel];
  assign g_ld   = req_ld[sel];
  assign g_last = req_last[sel];
  assign g_data = sel ? req_data[15:8]
                      : req_data[7:0];
  assign accept = (state == GRANT) && g_req
                  && g_ld && tx_empty;
  assign tx_enable = |gnt;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;

  // Cycles spent in GRANT since entry or the last accepted byte.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state != GRANT || accept)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tmo = (state == GRANT) && g_req
               && !accept && (cnt == LIM);
`else
  assign tmo = 1'b0;
`endif

  // State, grant, latched byte and last-served pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= 2'b00;
      byte_q <= 8'h00;
      last_q <= 1'b0;
      ptr    <= 1'b1;
    end else begin
      state  <= state_nx;
      gnt    <= gnt_nx;
      byte_q <= byte_nx;
      last_q <= last_nx;
      ptr    <= ptr_nx;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx     = state;
    gnt_nx       = gnt;
    byte_nx      = byte_q;
    last_nx      = last_q;
    ptr_nx       = ptr;
    req_ack      = 2'b00;
    tx_data      = 8'h00;
    ld_tx_data   = 1'b0;
    timeout_flag = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          unique case (1'b1)
            (req == 2'b11):
              gnt_nx = ptr ? 2'b01 : 2'b10;
            (req == 2'b01): gnt_nx = 2'b01;
            (req == 2'b10): gnt_nx = 2'b10;
          endcase
        end
      end
      GRANT: begin
        if (!g_req) begin
          state_nx = IDLE;
          gnt_nx   = 2'b00;
          ptr_nx   = sel;
        end else if (accept) begin
          req_ack  = gnt;
          byte_nx  = g_data;
          last_nx  = g_last;
          state_nx = LOAD;
        end else if (tmo) begin
          timeout_flag = 1'b1;
          state_nx     = IDLE;
          gnt_nx       = 2'b00;
          ptr_nx       = sel;
        end
      end
      LOAD: begin
        tx_data    = byte_q;
        ld_tx_data = 1'b1;
        state_nx   = HOLD;
      end
      HOLD: begin
        tx_data  = byte_q;
        state_nx = WAIT_TX;
      end
      WAIT_TX: begin
        tx_data = byte_q;
        if (tx_empty) begin
          if (last_q) begin
            state_nx = IDLE;
            gnt_nx   = 2'b00;
            ptr_nx   = sel;
          end else begin
            state_nx = GRANT;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized packet traffic
// checked against a packet-level model of the arbiter.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, req_ld, req_last;
  logic [15:0] req_data;
  logic        tx_empty;
  logic [1:0]  gnt, req_ack;
  logic [7:0]  tx_data;
  logic        ld_tx_data, tx_enable, timeout_flag;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_data(req_data),
    .req_ld(req_ld), .req_last(req_last),
    .gnt(gnt), .req_ack(req_ack),
    .tx_data(tx_data), .ld_tx_data(ld_tx_data),
    .tx_enable(tx_enable), .tx_empty(tx_empty),
    .timeout_flag(timeout_flag)
  );

  // Sender queues hold {last, byte}; exp_q is the wire order.
  logic [8:0] sq0[$], sq1[$];
  logic [7:0] exp_q[$];
  int gorder[$], zq[$], rq[$];
  bit en0, en1, ovr_ld0;
  logic [7:0] ovr_d0;
  int ldp, dly_lo, dly_hi, busy;
  int cyc, n_ld, n_ack0, n_ack1, n_tmo;
  int tmo_cyc, first_ld, bad_inv;
  logic [1:0] gnt_prev;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [8:0] f0, f1;
    @(posedge clk);
    #1;
    f0 = (sq0.size() > 0) ? sq0[0] : 9'h0;
    f1 = (sq1.size() > 0) ? sq1[0] : 9'h0;
    req[0] = en0 && (sq0.size() > 0);
    req[1] = en1 && (sq1.size() > 0);
    req_ld[0] = ovr_ld0 ||
      (req[0] && ($urandom_range(99) < ldp));
    req_ld[1] = req[1] &&
      ($urandom_range(99) < ldp);
    req_data[7:0]  = ovr_ld0 ? ovr_d0 : f0[7:0];
    req_data[15:8] = f1[7:0];
    req_last = {f1[8], f0[8]};
    tx_empty = (busy == 0);
    #1;
    cyc++;
    if (req_ack[0]) begin
      n_ack0++;
      if (sq0.size() > 0) void'(sq0.pop_front());
    end
    if (req_ack[1]) begin
      n_ack1++;
      if (sq1.size() > 0) void'(sq1.pop_front());
    end
    if (ld_tx_data) begin
      n_ld++;
      if (first_ld < 0) first_ld = cyc;
      if (exp_q.size() > 0)
        chk("tx_byte", 32'(tx_data),
            32'(exp_q.pop_front()));
    end
    if (gnt_prev == 2'b00 && gnt != 2'b00) begin
      gorder.push_back(int'(gnt[1]));
      rq.push_back(cyc);
    end
    if (gnt_prev != 2'b00 && gnt == 2'b00)
      zq.push_back(cyc);
    gnt_prev = gnt;
    if (timeout_flag) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
    if (tx_enable !== (|gnt) || gnt == 2'b11)
      bad_inv++;
    if (busy > 0) busy--;
    if (ld_tx_data)
      busy = $urandom_range(dly_hi, dly_lo);
  endtask

  task automatic clr();
    exp_q.delete();
    gorder.delete();
    zq.delete();
    rq.delete();
    n_ld = 0; n_ack0 = 0; n_ack1 = 0;
    n_tmo = 0; first_ld = -1; tmo_cyc = -1;
    ldp = 100; dly_lo = 4; dly_hi = 4;
    ovr_ld0 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en0 = 0; en1 = 0;
    sq0.delete(); sq1.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(gnt == 2'b00 && busy == 0 &&
                 exp_q.size() == 0) && n < budget);
    chk("done_bound", 32'(n >= budget), 0);
  endtask

  function automatic int order_code();
    int c = 0;
    foreach (gorder[i]) c = c * 2 + gorder[i];
    return c;
  endfunction

  task automatic add_pkt(input int p, input int len,
                         input logic [7:0] b0);
    for (int i = 0; i < len; i++) begin
      logic [7:0] b = b0 + 8'(i);
      logic [8:0] e = {(i == len - 1), b};
      if (p == 0) sq0.push_back(e);
      else        sq1.push_back(e);
      exp_q.push_back(b);
    end
  endtask

  initial begin
    int n, g, held, tot;
    rst = 1'b1; req = '0; req_ld = '0;
    req_last = '0; req_data = '0;
    tx_empty = 1'b1; busy = 0; cyc = 0;
    bad_inv = 0; gnt_prev = 2'b00;
    ovr_d0 = 8'hAA;
    clr();

    // Reset values
    do_reset();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_txd", 32'(tx_data), 0);
    chk("rst_ld", 32'(ld_tx_data), 0);
    chk("rst_en", 32'(tx_enable), 0);
    chk("rst_tmo", 32'(timeout_flag), 0);

    // Single port, three bytes, latency
    clr();
    sq0.push_back({1'b0, 8'h11});
    sq0.push_back({1'b0, 8'h22});
    sq0.push_back({1'b1, 8'h33});
    exp_q = '{8'h11, 8'h22, 8'h33};
    en0 = 1;
    tick();
    chk("lat_idle_gnt", 32'(gnt), 0);
    tick();
    chk("lat_grant_gnt", 32'(gnt), 1);
    chk("lat_grant_ack", 32'(req_ack), 1);
    tick();
    chk("lat_load_ld", 32'(ld_tx_data), 1);
    chk("lat_load_txd", 32'(tx_data), 32'h11);
    tick();
    chk("hold_ld", 32'(ld_tx_data), 0);
    chk("hold_txd", 32'(tx_data), 32'h11);
    run_until_done(100);
    chk("p0_ld_cnt", 32'(n_ld), 3);
    chk("p0_ack0", 32'(n_ack0), 3);
    chk("p0_ack1", 32'(n_ack1), 0);
    chk("p0_gnt_end", 32'(gnt), 0);
    chk("p0_txd_idle", 32'(tx_data), 0);
    chk("p0_grants", 32'(gorder.size()), 1);
    en0 = 0;

    // Both ports, two packets each, alternation
    do_reset();
    clr();
    dly_lo = 0; dly_hi = 5;
    add_pkt(0, 2, 8'hA0);
    add_pkt(1, 2, 8'hB0);
    add_pkt(0, 2, 8'hA2);
    add_pkt(1, 2, 8'hB2);
    en0 = 1; en1 = 1;
    run_until_done(400);
    chk("rr_ld_cnt", 32'(n_ld), 8);
    chk("rr_grants", 32'(gorder.size()), 4);
    chk("rr_order", 32'(order_code()), 32'b0101);
    en0 = 0; en1 = 0;

    // Strobe from non-granted port is ignored
    clr();
    add_pkt(1, 3, 8'h51);
    en1 = 1;
    n = 0;
    while (gnt != 2'b10 && n < 10) begin
      tick();
      n++;
    end
    ovr_ld0 = 1;
    repeat (20) tick();
    ovr_ld0 = 0;
    run_until_done(100);
    chk("ng_ack0", 32'(n_ack0), 0);
    chk("ng_ld_cnt", 32'(n_ld), 3);
    chk("ng_ack1", 32'(n_ack1), 3);
    en1 = 0;

    // Abort after first byte, other port follows
    do_reset();
    clr();
    sq0.push_back({1'b0, 8'hC0});
    sq0.push_back({1'b0, 8'hC1});
    sq0.push_back({1'b1, 8'hC2});
    add_pkt(1, 2, 8'hD0);
    exp_q = '{8'hC0, 8'hD0, 8'hD1};
    en0 = 1; en1 = 1;
    n = 0;
    while (n_ack0 < 1 && n < 20) begin
      tick();
      n++;
    end
    en0 = 0;
    run_until_done(200);
    chk("ab_ld_cnt", 32'(n_ld), 3);
    chk("ab_ack0", 32'(n_ack0), 1);
    chk("ab_order", 32'(order_code()), 32'b01);
    chk("ab_release",
        (zq.size() > 0) ? 32'(zq[0] - first_ld) : 0,
        7);
    chk("ab_next_gnt",
        (rq.size() > 1 && zq.size() > 0)
          ? 32'(rq[1] - zq[0]) : 0,
        1);
    sq0.delete();
    en1 = 0;

    // Stalled grantee
    clr();
    ldp = 0;
    sq0.push_back({1'b1, 8'hE0});
    en0 = 1;
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (gnt != 2'b01 && n < 10) begin
      tick();
      n++;
    end
    g = cyc;
    n = 0;
    while (gnt != 2'b00 && n < 40) begin
      tick();
      n++;
    end
    en0 = 0;
    chk("tmo_pulses", 32'(n_tmo), 1);
    chk("tmo_cycle", 32'(tmo_cyc - g), 15);
    chk("tmo_release",
        (zq.size() > 0) ? 32'(zq[0] - g) : 0, 16);
    run_until_done(40);
`else
    held = 0;
    repeat (1100) begin
      tick();
      if (gnt == 2'b01) held++;
    end
    chk("hold_cycles", 32'(held), 1099);
    chk("hold_no_tmo", 32'(n_tmo), 0);
    en0 = 0;
    run_until_done(20);
    chk("hold_abort_gnt", 32'(gnt), 0);
`endif
    sq0.delete();

    // Reset during HOLD
    clr();
    add_pkt(1, 1, 8'hF0);
    en1 = 1;
    n = 0;
    while (n_ld < 1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_gnt", 32'(gnt), 0);
    chk("mrst_ld", 32'(ld_tx_data), 0);
    chk("mrst_txd", 32'(tx_data), 0);
    chk("mrst_en", 32'(tx_enable), 0);
    chk("mrst_ack", 32'(req_ack), 0);
    clr();
    sq0.delete(); sq1.delete();
    add_pkt(0, 1, 8'h61);
    add_pkt(1, 1, 8'h71);
    en0 = 1; en1 = 1;
    run_until_done(200);
    chk("mrst_first",
        (gorder.size() > 0) ? 32'(gorder[0]) : 9, 0);
    chk("mrst_ld_cnt", 32'(n_ld), 2);

    // Randomized packet traffic, both ports busy
    for (int r = 0; r < 3; r++) begin
      clr();
      ldp = 70; dly_lo = 0; dly_hi = 6;
      tot = 0;
      for (int k = 0; k < 4; k++) begin
        n = $urandom_range(4, 1);
        add_pkt(0, n, 8'($urandom));
        tot += n;
        n = $urandom_range(4, 1);
        add_pkt(1, n, 8'($urandom));
        tot += n;
      end
      run_until_done(3000);
      chk("rnd_ld_cnt", 32'(n_ld), 32'(tot));
      chk("rnd_ack_cnt",
          32'(n_ack0 + n_ack1), 32'(tot));
      chk("rnd_order", 32'(order_code()), 32'h55);
    end

    chk("invariants", 32'(bad_inv), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
